// File: rtl/pulse_stretcher_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
package pulse_stretcher_pkg;

    // Window phases: idle, level held high, forced low gap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Width needed to hold the largest reload value (max(hold, gap) - 1).
    // Clamped so the counter is always at least one bit wide.
    function automatic int counter_width(input int hold_cycles, input int gap_cycles);
        int max_val;
        max_val = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        if (max_val < 2) begin
            max_val = 2;
        end
        return $clog2(max_val);
    endfunction

endpackage

// File: rtl/pulse_stretcher_load_down_counter.sv
// Loadable down counter shared by the HOLD and GAP phases.
// Load has priority over decrement; decrement stops at zero.
module load_down_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Reload on request, otherwise count down toward zero without wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-width level windows,
// each followed by a forced low gap. Pulses that arrive while a window
// is running are queued (or retrigger the hold when enabled).
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int RETRIGGER   = 0,
    parameter int PEND_DEPTH  = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pulsein,
    output logic                              levelout,
    output logic                              busy,
    output logic [$clog2(PEND_DEPTH+1)-1:0]   pending,
    output logic                              overflow
);

    localparam int CW = counter_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int PW = $clog2(PEND_DEPTH + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [PW-1:0] PEND_MAX  = PW'(PEND_DEPTH);

    state_t          state;
    state_t          next_state;
    logic            cnt_load;
    logic [CW-1:0]   cnt_value;
    logic            cnt_dec;
    logic [CW-1:0]   cnt_count;
    logic            cnt_zero;
    logic            queue_pulse;
    logic            finish_window;
    logic [PW-1:0]   pending_next;
    logic            overflow_next;

    load_down_counter #(
        .WIDTH(CW)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .count      (cnt_count),
        .zero       (cnt_zero)
    );

    // Decide the next phase, counter action and queue update for this cycle.
    // A window ending (gap expiry, or hold expiry with no gap) consumes one
    // queued pulse, counting a pulse arriving in that same cycle as queued.
    always_comb begin
        next_state    = state;
        cnt_load      = 1'b0;
        cnt_value     = HOLD_LOAD;
        cnt_dec       = 1'b0;
        queue_pulse   = 1'b0;
        finish_window = 1'b0;
        pending_next  = pending;
        overflow_next = 1'b0;

        case (state)
            IDLE: begin
                if (pulsein) begin
                    next_state = HOLD;
                    cnt_load   = 1'b1;
                    cnt_value  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if ((RETRIGGER != 0) && pulsein) begin
                    cnt_load  = 1'b1;
                    cnt_value = HOLD_LOAD;
                end else if (cnt_zero) begin
                    if (GAP_CYCLES > 0) begin
                        next_state  = GAP;
                        cnt_load    = 1'b1;
                        cnt_value   = GAP_LOAD;
                        queue_pulse = pulsein;
                    end else begin
                        finish_window = 1'b1;
                    end
                end else begin
                    cnt_dec     = 1'b1;
                    queue_pulse = pulsein;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    finish_window = 1'b1;
                end else begin
                    cnt_dec     = 1'b1;
                    queue_pulse = pulsein;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (finish_window) begin
            if ((pending != '0) || pulsein) begin
                next_state   = HOLD;
                cnt_load     = 1'b1;
                cnt_value    = HOLD_LOAD;
                pending_next = pulsein ? pending : (pending - PW'(1));
            end else begin
                next_state = IDLE;
            end
        end

        if (queue_pulse) begin
            if (pending == PEND_MAX) begin
                overflow_next = 1'b1;
            end else begin
                pending_next = pending + PW'(1);
            end
        end
    end

    // Register phase and all outputs so consumers see glitch-free levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            levelout <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= next_state;
            levelout <= (next_state == HOLD);
            busy     <= (next_state != IDLE);
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: three configurations share one
// pulse stream; a window-timeline model predicts every output each cycle.
module tb_pulse_stretcher;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst;
    logic pulsein;

    logic       level_a, busy_a, ovf_a;
    logic [1:0] pend_a;
    logic       level_b, busy_b, ovf_b;
    logic [1:0] pend_b;
    logic       level_c, busy_c, ovf_c;
    logic [1:0] pend_c;

    typedef struct {
        int dut;
        int cycle;
        bit level;
        bit busy;
        int pend;
        bit ovf;
    } exp_t;

    exp_t sb_q[$];

    int cyc = 0;
    int checks = 0;
    int fails = 0;

    // Configurations: hold, gap, retrigger, queue depth
    int cfg_h[NDUT] = '{4, 4, 3};
    int cfg_g[NDUT] = '{2, 2, 0};
    int cfg_r[NDUT] = '{0, 1, 0};
    int cfg_d[NDUT] = '{3, 3, 2};

    // Model: high cycles left, gap cycles left, queued pulses, overflow flag
    int hold_left[NDUT];
    int gap_left[NDUT];
    int pend_m[NDUT];
    bit ovf_m[NDUT];

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0), .PEND_DEPTH(3)) dut_a (
        .clk(clk), .rst(rst), .pulsein(pulsein),
        .levelout(level_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
    );

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1), .PEND_DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .pulsein(pulsein),
        .levelout(level_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
    );

    pulse_stretcher #(.HOLD_CYCLES(3), .GAP_CYCLES(0), .RETRIGGER(0), .PEND_DEPTH(2)) dut_c (
        .clk(clk), .rst(rst), .pulsein(pulsein),
        .levelout(level_c), .busy(busy_c), .pending(pend_c), .overflow(ovf_c)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to align predictions with DUT outputs.
    always @(posedge clk) cyc = cyc + 1;

    // Advance one model by one clock given the inputs seen in that cycle.
    task automatic modelStep(input int k, input bit r, input bit p);
        int  eff;
        bit  reload;
        if (r) begin
            hold_left[k] = 0;
            gap_left[k]  = 0;
            pend_m[k]    = 0;
            ovf_m[k]     = 1'b0;
        end else begin
            ovf_m[k] = 1'b0;
            reload   = 1'b0;
            if (hold_left[k] == 0 && gap_left[k] == 0) begin
                if (p) begin
                    hold_left[k] = cfg_h[k];
                    gap_left[k]  = cfg_g[k];
                end
            end else begin
                if (hold_left[k] > 0) begin
                    if (cfg_r[k] != 0 && p) begin
                        hold_left[k] = cfg_h[k];
                        reload = 1'b1;
                    end else begin
                        hold_left[k] = hold_left[k] - 1;
                    end
                end else begin
                    gap_left[k] = gap_left[k] - 1;
                end
                if (!reload) begin
                    if (hold_left[k] == 0 && gap_left[k] == 0) begin
                        eff = pend_m[k] + (p ? 1 : 0);
                        if (eff > 0) begin
                            hold_left[k] = cfg_h[k];
                            gap_left[k]  = cfg_g[k];
                            pend_m[k]    = eff - 1;
                        end
                    end else if (p) begin
                        if (pend_m[k] == cfg_d[k]) ovf_m[k] = 1'b1;
                        else pend_m[k] = pend_m[k] + 1;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs and queue the predicted outputs after the next edge.
    task automatic applyStimulus(input bit r, input bit p);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = r;
        pulsein = p;
        for (int k = 0; k < NDUT; k++) begin
            modelStep(k, r, p);
            e.dut   = k;
            e.cycle = cyc + 1;
            e.level = (hold_left[k] > 0);
            e.busy  = (hold_left[k] > 0) || (gap_left[k] > 0);
            e.pend  = pend_m[k];
            e.ovf   = ovf_m[k];
            sb_q.push_back(e);
        end
    endtask

    // Compare one named field against its prediction.
    task automatic compareField(input string name, input int dut, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, dut, cyc, actual, expected);
        end
    endtask

    // Check a popped prediction against the matching DUT.
    task automatic checkOutput(input exp_t e);
        int lv, bs, pd, ov;
        case (e.dut)
            0:       begin lv = int'(level_a); bs = int'(busy_a); pd = int'(pend_a); ov = int'(ovf_a); end
            1:       begin lv = int'(level_b); bs = int'(busy_b); pd = int'(pend_b); ov = int'(ovf_b); end
            default: begin lv = int'(level_c); bs = int'(busy_c); pd = int'(pend_c); ov = int'(ovf_c); end
        endcase
        compareField("levelout", e.dut, lv, int'(e.level));
        compareField("busy",     e.dut, bs, int'(e.busy));
        compareField("pending",  e.dut, pd, e.pend);
        compareField("overflow", e.dut, ov, int'(e.ovf));
    endtask

    // Monitor: after each edge, pop every prediction due by now.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb_q.size() > 0 && sb_q[0].cycle <= cyc) begin
                e = sb_q.pop_front();
                checkOutput(e);
            end
        end
    end

    // Pulses at the listed cycle offsets, then idle filler.
    task automatic pulsePattern(input int len, input int unsigned mask);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b0, (i < 32) ? mask[i] : 1'b0);
        end
    endtask

    // Stimulus: directed scenarios, reset mid-window, then random traffic.
    initial begin
        rst     = 1'b1;
        pulsein = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            hold_left[k] = 0;
            gap_left[k]  = 0;
            pend_m[k]    = 0;
            ovf_m[k]     = 1'b0;
        end

        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);

        pulsePattern(12, 32'h0000_0001);
        pulsePattern(16, 32'h0000_0005);
        pulsePattern(16, 32'h0000_0009);
        pulsePattern(30, 32'h0000_003F);
        pulsePattern(16, 32'h0000_0003);

        pulsePattern(4, 32'h0000_000F);
        applyStimulus(1'b1, 1'b1);
        pulsePattern(12, 32'h0000_0000);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35));
        end
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, ($urandom_range(0, 99) < 80));
        end
        pulsePattern(20, 32'h0000_0000);

        @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle pulses (as produced by the rising-edge detector) back into level windows: every accepted input pulse produces an output level held high for exactly HOLD_CYCLES clocks, followed by a mandatory low gap of GAP_CYCLES clocks. Pulses arriving while a window or gap is in progress are either queued in a saturating pending counter or, in retrigger mode, extend the current window. The block sits downstream of edge/event detectors and drives level-sensitive consumers such as LEDs, enables and slow peripherals.

## Interface

- HOLD_CYCLES, 4, output high time per accepted pulse; legal range ≥1
- GAP_CYCLES, 2, forced low time after each window; legal range ≥0
- RETRIGGER, 0, 1 = pulse during HOLD reloads the hold counter; 0 = pulse is queued
- PEND_DEPTH, 3, maximum queued pulses; legal range ≥1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pulsein  in  1  event input, sampled every clock, normally one cycle wide
- levelout  out  1  stretched level (registered)
- busy  out  1  high whenever state ≠ IDLE (registered)
- pending  out  $clog2(PEND_DEPTH+1)  queued pulse count (registered)
- overflow  out  1  one-cycle pulse: a pulse was dropped because pending was already PEND_DEPTH

## Operation

- States: IDLE, HOLD, GAP. levelout = (state == HOLD); busy = (state ≠ IDLE).
- Reset: state IDLE, levelout 0, busy 0, pending 0, overflow 0, counter 0. rst dominates pulsein; reset mid-window clears everything, including queued pulses.
- IDLE: pulsein=1 → HOLD, counter loaded HOLD_CYCLES-1. Pending stays 0.
- HOLD, RETRIGGER=1: pulsein=1 reloads counter to HOLD_CYCLES-1; pending unaffected.
- HOLD with RETRIGGER=0, and GAP in either mode: pulsein=1 increments pending; if pending==PEND_DEPTH the pulse is dropped, pending holds, overflow=1 next cycle.
- Counter decrements each cycle in HOLD/GAP; expiry = counter==0 and no reload this cycle.
- HOLD expiry: GAP_CYCLES>0 → GAP, counter GAP_CYCLES-1. GAP_CYCLES==0 → behaves as GAP expiry.
- GAP expiry: let eff = pending + pulsein. eff>0 → HOLD with counter HOLD_CYCLES-1; pending becomes eff-1 (pulse in same cycle as consume: net pending unchanged). eff==0 → IDLE.
- With GAP_CYCLES==0 back-to-back windows merge; levelout stays high continuously.
- Pending never exceeds PEND_DEPTH; never wraps below 0.

## Timing

- Cycle n = interval after clock edge n. pulsein high in cycle 0 → levelout high in cycles 1..HOLD_CYCLES (latency 1, exact width HOLD_CYCLES).
- HOLD_CYCLES=4, GAP_CYCLES=2: levelout high 1–4, low 5–6 (GAP), busy high 1–6, IDLE from cycle 7.
- Pulse in last GAP cycle with pending=0 → next HOLD starts the following cycle, no IDLE cycle in between.
- overflow asserts in the cycle after the dropped pulse, for exactly one cycle.
- pending updates one cycle after the pulse that changes it.

## Structure

- Package pulse_stretcher_pkg: state enum typedef (IDLE, HOLD, GAP) and the counter width function/constant derived from max(HOLD_CYCLES, GAP_CYCLES).
- One sub-module: load_down_counter (load, load value, decrement enable, zero flag), shared by HOLD and GAP.
- Top holds FSM, pending counter and overflow register; all outputs registered.

## Test plan

- Defaults, single pulse in cycle 0 → levelout high cycles 1–4, low 5–6, busy falls at cycle 7, pending stays 0.
- RETRIGGER=0, pulses in cycles 0 and 2 → pending=1 from cycle 3, second window cycles 7–10, pending=0 from cycle 7.
- RETRIGGER=1, pulses in cycles 0 and 3 → levelout high cycles 1–7 continuous, then GAP 8–9.
- PEND_DEPTH=3, pulsein held high 6 cycles from IDLE → pending 1,2,3 then overflow pulses on cycles 5 and 6; total windows = 4.
- GAP_CYCLES=0, pulses in cycles 0 and 1 → levelout high cycles 1–8 unbroken.
- rst asserted in cycle 2 of a window with pending=2 → cycle 3: levelout 0, busy 0, pending 0; pulsein during rst ignored.
